// File: rtl/spmi_capture_ctrl.sv
// SPMI packet capture controller: trigger match, bounded capture into a show-ahead FIFO.
// Optional macro SPMI_TRIGGER_EN enables the masked trigger compare; otherwise any packet triggers.
module spmi_capture_ctrl #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  sysclk,
  input  logic                  reset_n,
  input  logic                  arm,
  input  logic                  abort,
  input  logic [7:0]            cap_limit,
  input  logic [15:0]           trig_val,
  input  logic [15:0]           trig_mask,
  input  logic [15:0]           pkt_in,
  input  logic                  pkt_valid,
  output logic                  pkt_fetched,
  input  logic                  pkt_overflow,
  input  logic                  rd_en,
  output logic [15:0]           rd_data,
  output logic                  rd_empty,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [7:0]            drop_cnt,
  output logic [1:0]            state,
  output logic                  lost
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   C_FULL    = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   C_CNT_ONE = (DEPTH_LOG2 + 1)'(1'b1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_fetched;
  logic [7:0]              r_cap_cnt;
  logic [7:0]              w_cap_nxt;
  logic [7:0]              r_drop;
  logic                    r_lost;
  logic [15:0]             r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   r_wptr;
  logic [DEPTH_LOG2-1:0]   r_rptr;
  logic [DEPTH_LOG2:0]     r_count;

  logic w_fetch;
  logic w_arm;
  logic w_match;
  logic w_wr;
  logic w_pop;
  logic w_full;
  logic w_wr_ok;
  logic w_drop;

  assign w_fetch = pkt_valid & ~r_fetched;
  // abort has priority: arm together with abort neither flushes nor re-arms
  assign w_arm   = arm & ~abort;

`ifdef SPMI_TRIGGER_EN
  assign w_match = ((pkt_in ^ trig_val) & trig_mask) == 16'h0000;
`else
  logic w_unused_trig;
  assign w_unused_trig = ^{trig_val, trig_mask};
  assign w_match = 1'b1;
`endif

  assign w_full  = (r_count == C_FULL);
  assign w_pop   = rd_en & (r_count != {(DEPTH_LOG2 + 1){1'b0}}) & ~w_arm;
  assign w_wr_ok = w_wr & (~w_full | w_pop);
  assign w_drop  = w_wr & w_full & ~w_pop;

  // Next-state and capture-count decode
  always_comb begin
    w_state_nxt = r_state;
    w_cap_nxt   = r_cap_cnt;
    w_wr        = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else if (arm) begin
      w_state_nxt = ST_ARMED;
      w_cap_nxt   = 8'd0;
    end else begin
      case (r_state)
        ST_ARMED: begin
          if (w_fetch && w_match) begin
            w_wr        = 1'b1;
            w_cap_nxt   = 8'd1;
            w_state_nxt = (cap_limit == 8'd1) ? ST_DONE : ST_CAPTURE;
          end else begin
            w_state_nxt = ST_ARMED;
          end
        end
        ST_CAPTURE: begin
          if (w_fetch) begin
            w_wr      = 1'b1;
            w_cap_nxt = r_cap_cnt + 8'd1;
            if ((cap_limit != 8'd0) && (w_cap_nxt == cap_limit)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_state_nxt = ST_CAPTURE;
            end
          end else begin
            w_state_nxt = ST_CAPTURE;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State, fetch handshake and capture count
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_fetched <= 1'b0;
      r_cap_cnt <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_fetched <= w_fetch;
      r_cap_cnt <= w_cap_nxt;
    end
  end

  // FIFO pointers, occupancy and saturating drop counter
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr  <= {DEPTH_LOG2{1'b0}};
      r_rptr  <= {DEPTH_LOG2{1'b0}};
      r_count <= {(DEPTH_LOG2 + 1){1'b0}};
      r_drop  <= 8'd0;
    end else if (w_arm) begin
      r_wptr  <= {DEPTH_LOG2{1'b0}};
      r_rptr  <= {DEPTH_LOG2{1'b0}};
      r_count <= {(DEPTH_LOG2 + 1){1'b0}};
      r_drop  <= 8'd0;
    end else begin
      if (w_wr_ok) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      case ({w_wr_ok, w_pop})
        2'b10:   r_count <= r_count + C_CNT_ONE;
        2'b01:   r_count <= r_count - C_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop && (r_drop != 8'hFF)) begin
        r_drop <= r_drop + 8'd1;
      end
    end
  end

  // Storage array; stale words are hidden by the empty gating on rd_data
  always_ff @(posedge sysclk) begin
    if (w_wr_ok) begin
      r_mem[r_wptr] <= pkt_in;
    end
  end

  // Sticky overflow flag, cleared only by arm or reset
  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_lost <= 1'b0;
    end else if (w_arm) begin
      r_lost <= 1'b0;
    end else if (pkt_overflow && ((r_state == ST_ARMED) || (r_state == ST_CAPTURE))) begin
      r_lost <= 1'b1;
    end
  end

  assign pkt_fetched = r_fetched;
  assign rd_empty    = (r_count == {(DEPTH_LOG2 + 1){1'b0}});
  assign rd_data     = rd_empty ? 16'h0000 : r_mem[r_rptr];
  assign fifo_count  = r_count;
  assign drop_cnt    = r_drop;
  assign state       = r_state;
  assign lost        = r_lost;

endmodule

// File: tb/tb_spmi_capture_ctrl.sv
// Directed self-checking bench for spmi_capture_ctrl (default DEPTH_LOG2=3).
module tb_spmi_capture_ctrl;

`ifdef SPMI_TRIGGER_EN
  localparam bit TRIG = 1'b1;
`else
  localparam bit TRIG = 1'b0;
`endif

  logic        sysclk = 1'b0;
  logic        reset_n;
  logic        arm, abort, pkt_valid, pkt_overflow, rd_en;
  logic [7:0]  cap_limit;
  logic [15:0] trig_val, trig_mask, pkt_in;
  logic        pkt_fetched, rd_empty, lost;
  logic [15:0] rd_data;
  logic [3:0]  fifo_count;
  logic [7:0]  drop_cnt;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_err = 0;

  spmi_capture_ctrl #(.DEPTH_LOG2(3)) dut (
    .sysclk(sysclk), .reset_n(reset_n), .arm(arm), .abort(abort),
    .cap_limit(cap_limit), .trig_val(trig_val), .trig_mask(trig_mask),
    .pkt_in(pkt_in), .pkt_valid(pkt_valid), .pkt_fetched(pkt_fetched),
    .pkt_overflow(pkt_overflow), .rd_en(rd_en), .rd_data(rd_data),
    .rd_empty(rd_empty), .fifo_count(fifo_count), .drop_cnt(drop_cnt),
    .state(state), .lost(lost)
  );

  always #5 sysclk = ~sysclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // present one packet and hold it until acknowledged (bounded)
  task automatic send(input logic [15:0] w);
    @(negedge sysclk);
    pkt_in = w;
    pkt_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge sysclk);
      if (pkt_fetched) break;
    end
    check_eq("fetch_ack", 32'(pkt_fetched), 32'h1);
    pkt_valid = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    @(negedge sysclk);
    check_eq(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    @(negedge sysclk);
    rd_en = 1'b0;
  endtask

  task automatic pulse(input logic a, input logic b);
    @(negedge sysclk);
    arm = a;
    abort = b;
    @(negedge sysclk);
    arm = 1'b0;
    abort = 1'b0;
  endtask

  logic [15:0] exp19 [3];
  logic [4:0]  pat;

  initial begin
    reset_n = 1'b0; arm = 1'b0; abort = 1'b0; pkt_valid = 1'b0; pkt_overflow = 1'b0;
    rd_en = 1'b0; cap_limit = 8'd0; trig_val = 16'h0000; trig_mask = 16'h0000; pkt_in = 16'h0000;
    repeat (2) @(negedge sysclk);
    check_eq("rst_state", 32'(state), 32'h0);
    check_eq("rst_empty", 32'(rd_empty), 32'h1);
    check_eq("rst_count", 32'(fifo_count), 32'h0);
    check_eq("rst_rdata", 32'(rd_data), 32'h0);
    check_eq("rst_drop", 32'(drop_cnt), 32'h0);
    check_eq("rst_lost", 32'(lost), 32'h0);
    check_eq("rst_fetched", 32'(pkt_fetched), 32'h0);
    reset_n = 1'b1;

    // overflow in IDLE must not set lost
    @(negedge sysclk); pkt_overflow = 1'b1;
    @(negedge sysclk); pkt_overflow = 1'b0;
    check_eq("lost_idle", 32'(lost), 32'h0);

    // trigger then capture three
    cap_limit = 8'd3; trig_mask = 16'hFFFF; trig_val = 16'h01A5;
    pulse(1'b1, 1'b0);
    check_eq("armed", 32'(state), 32'h1);
    send(16'h0100); send(16'h01A5); send(16'h0001); send(16'h0002); send(16'h0003);
    check_eq("cap3_state", 32'(state), 32'h3);
    check_eq("cap3_count", 32'(fifo_count), 32'h3);
    check_eq("cap3_drop", 32'(drop_cnt), 32'h0);
    exp19[0] = TRIG ? 16'h01A5 : 16'h0100;
    exp19[1] = TRIG ? 16'h0001 : 16'h01A5;
    exp19[2] = TRIG ? 16'h0002 : 16'h0001;
    for (int i = 0; i < 3; i++) pop_chk("cap3_data", exp19[i]);
    check_eq("cap3_empty", 32'(rd_empty), 32'h1);

    // unlimited capture overfills the FIFO
    cap_limit = 8'd0; trig_mask = 16'h0000;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) send(16'h0A00 + 16'(i));
    check_eq("fill_count", 32'(fifo_count), 32'h8);
    check_eq("fill_drop", 32'(drop_cnt), 32'h2);
    check_eq("fill_state", 32'(state), 32'h2);

    // write and pop on the same edge while full
    @(negedge sysclk);
    check_eq("full_head", 32'(rd_data), 32'h0A00);
    pkt_in = 16'h0BEE; pkt_valid = 1'b1; rd_en = 1'b1;
    @(negedge sysclk);
    pkt_valid = 1'b0; rd_en = 1'b0;
    check_eq("wp_fetched", 32'(pkt_fetched), 32'h1);
    check_eq("wp_count", 32'(fifo_count), 32'h8);
    check_eq("wp_drop", 32'(drop_cnt), 32'h2);
    for (int i = 1; i < 8; i++) pop_chk("wp_data", 16'h0A00 + 16'(i));
    pop_chk("wp_last", 16'h0BEE);
    check_eq("drain_empty", 32'(rd_empty), 32'h1);
    @(negedge sysclk); rd_en = 1'b1;
    @(negedge sysclk); rd_en = 1'b0;
    check_eq("pop_empty_count", 32'(fifo_count), 32'h0);
    check_eq("pop_empty_flag", 32'(rd_empty), 32'h1);

    // drop counter saturation
    for (int i = 0; i < 268; i++) send(16'h0D00 + 16'(i));
    check_eq("sat_drop", 32'(drop_cnt), 32'hFF);
    check_eq("sat_count", 32'(fifo_count), 32'h8);

    // held valid gives alternating acknowledge
    @(negedge sysclk);
    pkt_in = 16'h0E00; pkt_valid = 1'b1;
    pat = 5'b00000;
    for (int i = 0; i < 5; i++) begin
      @(negedge sysclk);
      pat = {pat[3:0], pkt_fetched};
    end
    pkt_valid = 1'b0;
    check_eq("fetch_pattern", 32'(pat), 32'h15);

    // arm with abort: abort wins, nothing flushed
    pulse(1'b1, 1'b1);
    check_eq("armabort_state", 32'(state), 32'h0);
    check_eq("armabort_count", 32'(fifo_count), 32'h8);
    check_eq("armabort_drop", 32'(drop_cnt), 32'hFF);
    send(16'h0F00);
    check_eq("idle_discard", 32'(fifo_count), 32'h8);

    pulse(1'b1, 1'b0);
    check_eq("flush_state", 32'(state), 32'h1);
    check_eq("flush_count", 32'(fifo_count), 32'h0);
    check_eq("flush_drop", 32'(drop_cnt), 32'h0);
    check_eq("flush_rdata", 32'(rd_data), 32'h0);

    // lost is sticky across abort, cleared by arm
    @(negedge sysclk); pkt_overflow = 1'b1;
    @(negedge sysclk); pkt_overflow = 1'b0;
    check_eq("lost_set", 32'(lost), 32'h1);
    pulse(1'b0, 1'b1);
    check_eq("lost_abort_state", 32'(state), 32'h0);
    check_eq("lost_kept", 32'(lost), 32'h1);
    @(negedge sysclk);
    arm = 1'b1; pkt_in = 16'h1234; pkt_valid = 1'b1;
    @(negedge sysclk);
    arm = 1'b0; pkt_valid = 1'b0;
    check_eq("armfetch_ack", 32'(pkt_fetched), 32'h1);
    check_eq("armfetch_count", 32'(fifo_count), 32'h0);
    check_eq("armfetch_state", 32'(state), 32'h1);
    check_eq("lost_cleared", 32'(lost), 32'h0);

    // asynchronous reset mid-capture
    for (int i = 0; i < 4; i++) send(16'h0C00 + 16'(i));
    check_eq("mid_count", 32'(fifo_count), 32'h4);
    check_eq("mid_state", 32'(state), 32'h2);
    @(negedge sysclk); pkt_overflow = 1'b1;
    @(negedge sysclk); pkt_overflow = 1'b0;
    check_eq("mid_lost", 32'(lost), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("arst_empty", 32'(rd_empty), 32'h1);
    check_eq("arst_state", 32'(state), 32'h0);
    check_eq("arst_lost", 32'(lost), 32'h0);
    check_eq("arst_count", 32'(fifo_count), 32'h0);
    @(negedge sysclk);
    reset_n = 1'b1;

    // trigger compare: enabled rejects 0x0BAD, disabled captures it
    cap_limit = 8'd1; trig_mask = 16'hFFFF; trig_val = 16'h1234;
    pulse(1'b1, 1'b0);
    send(16'h0BAD);
    @(negedge sysclk);
    check_eq("trig_state", 32'(state), TRIG ? 32'h1 : 32'h3);
    check_eq("trig_count", 32'(fifo_count), TRIG ? 32'h0 : 32'h1);
    check_eq("trig_rdata", 32'(rd_data), TRIG ? 32'h0 : 32'h0BAD);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
